iram_loader: RTL and testbench

- Parametrised instruction-RAM subsystem for the CPU top level.
- Replaces the bare single-cycle write port with:
  - a streaming load engine (valid/ready, narrow chunks assembled into words, base/length addressing);
  - CPU reset gating while a load is in progress.
- The CPU fetch port is unchanged in semantics: address in, registered data out one cycle later.

---
 rtl/iram_pkg.sv | 26 ++
 rtl/iram_dp.sv | 32 +++
 rtl/iram_loader.sv | 163 ++++++++++++++++
 tb/tb_iram_loader.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iram_pkg.sv
// Shared types and elaboration helpers for the instruction-RAM loader.
// Optional checksum support is enabled with IRAM_CSUM_EN (see iram_loader).
package iram_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  function automatic int calc_chunks(input int w, input int lw);
    return w / lw;
  endfunction

  // A one-chunk word still needs a 1-bit counter so the port stays legal.
  function automatic int calc_chunk_cnt_w(input int w, input int lw);
    int c;
    c = w / lw;
    return (c <= 1) ? 1 : $clog2(c);
  endfunction

  function automatic bit ratio_ok(input int w, input int lw);
    return (lw > 0) && (w >= lw) && ((w % lw) == 0);
  endfunction

endpackage

// File: rtl/iram_dp.sv
// Simple dual-port instruction RAM: one synchronous write port and one
// registered read port that returns the old word on a same-address collision.
module iram_dp #(
  parameter int width       = 16,
  parameter int iaddr_width = 8
) (
  input  logic                   clk,
  input  logic                   reset_i,
  input  logic                   we_i,
  input  logic [iaddr_width-1:0] waddr_i,
  input  logic [width-1:0]       wdata_i,
  input  logic [iaddr_width-1:0] raddr_i,
  output logic [width-1:0]       rdata_o
);

  logic [width-1:0] mem_q [2**iaddr_width];
  logic [width-1:0] rdata_q;

  // NOTE: the array has no reset so it maps onto block RAM; contents survive reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // NOTE: non-blocking assignments make a same-cycle read see the pre-write word.
  always_ff @(posedge clk) begin
    if (reset_i) rdata_q <= '0;
    else         rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/iram_loader.sv
// Instruction RAM with a streaming load engine and CPU hold control.
// Define IRAM_CSUM_EN to verify a per-load checksum and stay in HOLD on mismatch.
module iram_loader
  import iram_pkg::*;
#(
  parameter int width       = 16,
  parameter int iaddr_width = 8,
  parameter int ld_width    = 8,
  parameter bit boot_hold   = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [iaddr_width-1:0] iaddr,
  output logic [width-1:0]       idata,
  output logic                   cpu_reset,
  input  logic                   ld_start,
  input  logic [iaddr_width-1:0] ld_base,
  input  logic [iaddr_width-1:0] ld_count,
  input  logic [width-1:0]       ld_csum,
  input  logic                   ld_valid,
  input  logic [ld_width-1:0]    ld_data,
  output logic                   ld_ready,
  output logic                   ld_busy,
  output logic                   ld_done,
  output logic                   ld_err
);

  if (!ratio_ok(width, ld_width)) begin : g_bad_ratio
    $error("iram_loader: width must be an integer multiple of ld_width");
  end

  localparam int             CHUNKS      = calc_chunks(width, ld_width);
  localparam int             CW          = calc_chunk_cnt_w(width, ld_width);
  localparam logic [CW-1:0]  LAST_CHUNK  = CW'(CHUNKS - 1);
  localparam logic [iaddr_width:0] ONE_WORD = (iaddr_width+1)'(1);
  localparam state_e         RESET_STATE = boot_hold ? ST_HOLD : ST_RUN;

  state_e                 state_q;
  logic [iaddr_width-1:0] addr_q;
  logic [iaddr_width:0]   remain_q;
  logic [CW-1:0]          chunk_q;
  logic                   cpu_reset_q;
  logic                   ld_ready_q;
  logic                   ld_busy_q;
  logic                   ld_done_q;
  logic [width-1:0]       word_d;
  logic                   chunk_fire;
  logic                   word_fire;
  logic                   csum_bad;

  // ld_ready_q is only ever high in LOAD, so it doubles as the state qualifier.
  assign chunk_fire = ld_valid & ld_ready_q;
  assign word_fire  = chunk_fire & (chunk_q == LAST_CHUNK);

  // Little-endian assembly: older chunks sit below the incoming one.
  if (CHUNKS == 1) begin : g_one_chunk
    assign word_d = ld_data;
  end else begin : g_multi_chunk
    logic [width-ld_width-1:0] asm_q;
    assign word_d = {ld_data, asm_q};
    always_ff @(posedge clk) begin
      if (reset)           asm_q <= '0;
      else if (chunk_fire) asm_q <= word_d[width-1:ld_width];
    end
  end

`ifdef IRAM_CSUM_EN
  logic [width-1:0] csum_q;
  logic [width-1:0] csum_exp_q;
  logic             ld_err_q;

  assign csum_bad = (csum_q != csum_exp_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      csum_q     <= '0;
      csum_exp_q <= '0;
      ld_err_q   <= 1'b0;
    end else if (state_q != ST_LOAD) begin
      if (ld_start) begin
        csum_q     <= '0;
        csum_exp_q <= ld_csum;
        ld_err_q   <= 1'b0;
      end
    end else begin
      if (word_fire)                   csum_q   <= csum_q + word_d;
      if (remain_q == '0 && csum_bad)  ld_err_q <= 1'b1;
    end
  end

  assign ld_err = ld_err_q;
`else
  logic unused_csum;
  assign unused_csum = ^ld_csum;
  assign csum_bad    = 1'b0;
  assign ld_err      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RESET_STATE;
      cpu_reset_q <= boot_hold;
      ld_ready_q  <= 1'b0;
      ld_busy_q   <= 1'b0;
      ld_done_q   <= 1'b0;
      addr_q      <= '0;
      remain_q    <= '0;
      chunk_q     <= '0;
    end else begin
      ld_done_q <= 1'b0;
      case (state_q)
        ST_RUN, ST_HOLD: begin
          if (ld_start) begin
            state_q     <= ST_LOAD;
            cpu_reset_q <= 1'b1;
            ld_ready_q  <= 1'b1;
            ld_busy_q   <= 1'b1;
            addr_q      <= ld_base;
            remain_q    <= {ld_count == '0, ld_count};
            chunk_q     <= '0;
          end
        end
        ST_LOAD: begin
          if (chunk_fire) chunk_q <= (chunk_q == LAST_CHUNK) ? '0 : chunk_q + 1'b1;
          if (word_fire) begin
            addr_q   <= addr_q + 1'b1;
            remain_q <= remain_q - 1'b1;
            if (remain_q == ONE_WORD) begin
              ld_ready_q <= 1'b0;
              ld_done_q  <= 1'b1;
            end
          end
          // The done cycle is spent in LOAD so the checksum verdict is final.
          if (remain_q == '0) begin
            state_q     <= csum_bad ? ST_HOLD : ST_RUN;
            cpu_reset_q <= csum_bad;
            ld_busy_q   <= 1'b0;
          end
        end
        default: state_q <= RESET_STATE;
      endcase
    end
  end

  iram_dp #(
    .width       (width),
    .iaddr_width (iaddr_width)
  ) u_ram (
    .clk     (clk),
    .reset_i (reset),
    .we_i    (word_fire),
    .waddr_i (addr_q),
    .wdata_i (word_d),
    .raddr_i (iaddr),
    .rdata_o (idata)
  );

  assign cpu_reset = cpu_reset_q;
  assign ld_ready  = ld_ready_q;
  assign ld_busy   = ld_busy_q;
  assign ld_done   = ld_done_q;

endmodule

// File: tb/tb_iram_loader.sv
// Self-checking bench for iram_loader (width=16, iaddr_width=8, ld_width=8,
// boot_hold=1); checksum cases run when IRAM_CSUM_EN is defined.
module tb_iram_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  iaddr;
  logic [15:0] idata;
  logic        cpu_reset;
  logic        ld_start;
  logic [7:0]  ld_base;
  logic [7:0]  ld_count;
  logic [15:0] ld_csum;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_ready;
  logic        ld_busy;
  logic        ld_done;
  logic        ld_err;

  always #5 clk = ~clk;

  iram_loader #(
    .width       (16),
    .iaddr_width (8),
    .ld_width    (8),
    .boot_hold   (1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .iaddr     (iaddr),
    .idata     (idata),
    .cpu_reset (cpu_reset),
    .ld_start  (ld_start),
    .ld_base   (ld_base),
    .ld_count  (ld_count),
    .ld_csum   (ld_csum),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .ld_busy   (ld_busy),
    .ld_done   (ld_done),
    .ld_err    (ld_err)
  );

  logic [15:0] model [256];
  logic [15:0] exp_q [$];
  int n_checks = 0;
  int n_errs   = 0;
  int done_seen = 0;
  int chunks_acc = 0;

  always @(negedge clk) if (ld_done) done_seen++;
  always @(posedge clk) if (ld_valid && ld_ready) chunks_acc++;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [7:0] a);
    iaddr = a;
    exp_q.push_back(model[a]);
    tick();
    check($sformatf("fetch[%02h]", a), idata, exp_q.pop_front());
  endtask

  task automatic start_load(input logic [7:0] base, input logic [7:0] cnt, input logic [15:0] csum);
    ld_start = 1'b1;
    ld_base  = base;
    ld_count = cnt;
    ld_csum  = csum;
    tick();
    ld_start = 1'b0;
    check("start_busy", ld_busy, 1'b1);
    check("start_ready", ld_ready, 1'b1);
    check("start_cpu_reset", cpu_reset, 1'b1);
    check("start_err_clear", ld_err, 1'b0);
  endtask

  task automatic send_chunk(input logic [7:0] d);
    int n = 0;
    ld_valid = 1'b1;
    ld_data  = d;
    while (!ld_ready && n < 16) begin
      tick();
      n++;
    end
    check("chunk_ready", ld_ready, 1'b1);
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input int gap);
    for (int c = 0; c < 2; c++) begin
      repeat (gap) tick();
      send_chunk(w[c*8 +: 8]);
    end
  endtask

  task automatic finish_load(input logic exp_cpu_reset, input logic exp_err);
    int n = 0;
    while (!ld_done && n < 64) begin
      tick();
      n++;
    end
    check("done_pulse", ld_done, 1'b1);
    check("done_ready_low", ld_ready, 1'b0);
    check("done_cpu_held", cpu_reset, 1'b1);
    tick();
    check("done_single", ld_done, 1'b0);
    check("end_cpu_reset", cpu_reset, exp_cpu_reset);
    check("end_busy", ld_busy, 1'b0);
    check("end_err", ld_err, exp_err);
  endtask

  initial begin
    int d0;
    int a0;
    reset    = 1'b1;
    iaddr    = 8'h00;
    ld_start = 1'b0;
    ld_base  = 8'h00;
    ld_count = 8'h00;
    ld_csum  = 16'h0000;
    ld_valid = 1'b0;
    ld_data  = 8'h00;

    // Reset state
    tick();
    tick();
    check("rst_cpu_reset", cpu_reset, 1'b1);
    check("rst_idata", idata, 16'h0000);
    check("rst_ready", ld_ready, 1'b0);
    check("rst_done", ld_done, 1'b0);
    check("rst_busy", ld_busy, 1'b0);
    check("rst_err", ld_err, 1'b0);
    reset = 1'b0;
    repeat (3) tick();
    check("boot_hold", cpu_reset, 1'b1);

    // Basic two-word load with valid gaps and an ignored ld_start mid-load
    start_load(8'h10, 8'd2, 16'h0000);
    send_chunk(8'h34);
    repeat (2) tick();
    send_chunk(8'h12);
    ld_start = 1'b1;
    ld_base  = 8'h80;
    ld_count = 8'd5;
    tick();
    ld_start = 1'b0;
    check("start_ignored_busy", ld_busy, 1'b1);
    repeat (1) tick();
    send_chunk(8'h78);
    repeat (3) tick();
    d0 = done_seen;
    send_chunk(8'h56);
    model[8'h10] = 16'h1234;
    model[8'h11] = 16'h5678;
    finish_load(1'b0, 1'b0);
    check("done_once", done_seen - d0, 1);
    fetch(8'h11);
    fetch(8'h10);

    // Address wrap from 0xFF to 0x00, 0x01 untouched
    start_load(8'h00, 8'd2, 16'h0000);
    send_word(16'hAAAA, 0);
    send_word(16'hBBBB, 1);
    model[8'h00] = 16'hAAAA;
    model[8'h01] = 16'hBBBB;
    finish_load(1'b0, 1'b0);
    start_load(8'hFF, 8'd2, 16'h0000);
    send_word(16'hCCCC, 0);
    send_word(16'hDDDD, 0);
    model[8'hFF] = 16'hCCCC;
    model[8'h00] = 16'hDDDD;
    finish_load(1'b0, 1'b0);
    fetch(8'hFF);
    fetch(8'h00);
    fetch(8'h01);

    // Read/write collision returns the old word, then the new one
    start_load(8'h10, 8'd1, 16'h0000);
    send_chunk(8'hEF);
    iaddr = 8'h10;
    exp_q.push_back(model[8'h10]);
    send_chunk(8'hBE);
    check("collision_old", idata, exp_q.pop_front());
    model[8'h10] = 16'hBEEF;
    finish_load(1'b0, 1'b0);
    fetch(8'h10);

    // count=0 loads all 256 words
    a0 = chunks_acc;
    d0 = done_seen;
    start_load(8'h20, 8'd0, 16'h0000);
    for (int i = 0; i < 255; i++) begin
      send_word(16'(i * 257) ^ 16'h3C5A, 0);
      model[8'(8'h20 + i)] = 16'(i * 257) ^ 16'h3C5A;
    end
    check("full_no_early_done", done_seen - d0, 0);
    check("full_still_ready", ld_ready, 1'b1);
    send_word(16'(255 * 257) ^ 16'h3C5A, 0);
    model[8'h1F] = 16'(255 * 257) ^ 16'h3C5A;
    finish_load(1'b0, 1'b0);
    check("full_chunks", chunks_acc - a0, 512);
    fetch(8'h20);
    fetch(8'h1F);
    fetch(8'hFF);
    fetch(8'h11);

    // Reset after 3 of 4 chunks
    start_load(8'h40, 8'd2, 16'h0000);
    send_word(16'h1111, 0);
    send_chunk(8'h22);
    model[8'h40] = 16'h1111;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_cpu_reset", cpu_reset, 1'b1);
    check("midrst_ready", ld_ready, 1'b0);
    check("midrst_busy", ld_busy, 1'b0);
    check("midrst_done", ld_done, 1'b0);
    check("midrst_idata", idata, 16'h0000);
    fetch(8'h40);
    fetch(8'h41);

    // ld_valid outside LOAD is ignored
    a0 = chunks_acc;
    ld_valid = 1'b1;
    ld_data  = 8'h99;
    repeat (4) tick();
    check("idle_ready", ld_ready, 1'b0);
    ld_valid = 1'b0;
    check("idle_no_accept", chunks_acc - a0, 0);
    check("hold_persists", cpu_reset, 1'b1);
    fetch(8'h41);

    // Load from HOLD releases the CPU
    start_load(8'h41, 8'd1, 16'h0000);
    send_word(16'h4242, 2);
    model[8'h41] = 16'h4242;
    finish_load(1'b0, 1'b0);
    fetch(8'h41);

`ifdef IRAM_CSUM_EN
    // Checksum match -> RUN
    start_load(8'h50, 8'd2, 16'h0001);
    send_word(16'h8000, 0);
    send_word(16'h8001, 0);
    model[8'h50] = 16'h8000;
    model[8'h51] = 16'h8001;
    finish_load(1'b0, 1'b0);
    // Checksum mismatch -> HOLD with sticky error
    start_load(8'h50, 8'd2, 16'h0002);
    send_word(16'h8000, 0);
    send_word(16'h8001, 0);
    finish_load(1'b1, 1'b1);
    repeat (3) tick();
    check("err_sticky", ld_err, 1'b1);
    check("err_hold", cpu_reset, 1'b1);
    start_load(8'h52, 8'd1, 16'h0007);
    send_word(16'h0007, 0);
    model[8'h52] = 16'h0007;
    finish_load(1'b0, 1'b0);
    fetch(8'h52);
`else
    // Without checksum support ld_csum is ignored
    start_load(8'h50, 8'd2, 16'h0002);
    send_word(16'h8000, 0);
    send_word(16'h8001, 0);
    model[8'h50] = 16'h8000;
    model[8'h51] = 16'h8001;
    finish_load(1'b0, 1'b0);
    repeat (2) tick();
    check("no_csum_err", ld_err, 1'b0);
`endif
    fetch(8'h50);
    fetch(8'h51);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
